mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single `ram` port set (read/write strobes, wrdy/rrdy, exc) between the instruction-fetch port (m0) and the load/store port (m1).
- Serialises one transaction at a time and uses round-robin priority.
- Converts the ram busy/ready handshake into a simple req/ack/err protocol per master, with a watchdog timeout.
- Sits between the CPU32 core and `ram`.

Parameters:
- AW, 32, address width of master and ram ports.
- DW, 32, data width of master and ram ports.
- TIMEOUT, 255, maximum cycles spent waiting on ram before the transaction is aborted with err. Must be ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req, m1_req  in  1 each  transaction request; level, held until ack or err.
- m0_we, m1_we  in  1 each  1 = write, 0 = read; sampled with req.
- m0_addr, m1_addr  in  AW each  address.
- m0_wdata, m1_wdata  in  DW each  write data.
- m0_rdata, m1_rdata  out  DW each  read data, valid in the ack cycle.
- m0_ack, m1_ack  out  1 each  one-cycle completion pulse.
- m0_err, m1_err  out  1 each  one-cycle error pulse (ram exception or timeout); mutually exclusive with ack.
- mem_r_addr, mem_w_addr  out  AW each  ram read/write address.
- mem_w_line  out  DW  ram write data.
- mem_r_line  in  DW  ram read data.
- mem_read, mem_write  out  1 each  ram strobes.
- mem_rrdy, mem_wrdy  in  1 each  ram ready (high = idle/done, low = busy).
- mem_exc  in  1  ram exception.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0.
  - state=IDLE, rr_last=1 (m0 wins the first tie), timeout counter=0.
  - A reset mid-transaction drops the strobes immediately. No ack or err is issued for the aborted transaction.
- States: IDLE, WAIT_BUSY, WAIT_DONE, RESP, DRAIN.
- IDLE:
  - If exactly one req is high, grant that master.
  - If both are high, grant the master != rr_last.
  - On grant: latch we/addr/wdata into internal registers, set rr_last=grant, and go to WAIT_BUSY.
  - Strobe rises on the cycle after grant: mem_read=!we or mem_write=we, never both.
- Address routing:
  - Reads drive mem_r_addr=addr.
  - Writes drive mem_w_addr=addr and mem_w_line=wdata.
  - Unused ram address/data outputs hold their last value.
- WAIT_BUSY:
  - Strobe held.
  - Selected ready (rrdy for read, wrdy for write) going 0 → WAIT_DONE.
  - mem_exc=1 → RESP with err.
- WAIT_DONE:
  - Strobe held.
  - Selected ready returning 1 → capture mem_r_line (reads) and go to RESP with ack.
  - mem_exc=1 (with any ready value) → RESP with err; exc has priority over ready.
- Strobe release: strobe is deasserted on entry to RESP.
- Timeout:
  - The counter increments each cycle in WAIT_BUSY/WAIT_DONE and clears on entry to WAIT_BUSY.
  - Reaching TIMEOUT → drop strobe, pulse err, go to DRAIN.
- RESP:
  - The granted master's ack or err is high for exactly one cycle.
  - rdata is registered and holds until the next read completes for that master.
  - Next state is IDLE.
- DRAIN (after timeout):
  - Err is pulsed on the DRAIN entry cycle.
  - Remain in DRAIN until both mem_rrdy and mem_wrdy = 1, then go to IDLE.
  - No grants are made while in DRAIN.
- Throughput:
  - Minimum latency from grant to ack is 4 cycles (grant, busy, done, RESP).
  - One idle cycle occurs between transactions: a master whose req stays high is re-arbitrated in IDLE on the cycle after its ack.
- Fairness: with both reqs continuously high, grants strictly alternate m0, m1, m0, …
- Req changes while not granted are ignored. Changes to a granted master's inputs after grant are ignored (latched copy used).

Decomposition:
- Shared package cpu32_mem_pkg:
  - State enum (IDLE, WAIT_BUSY, WAIT_DONE, RESP, DRAIN).
  - Master index constants M_IFETCH=0, M_DATA=1.
  - Default AW/DW.
- One natural sub-module: rr_arb2, the 2-way round-robin grant logic holding rr_last.
- FSM, latches and timeout counter live in mem_arbiter.

Test Plan:
- Single read: m0_req, we=0, addr=0x10, ram returns 0x20 after 3 busy cycles → m0_ack one pulse, m0_rdata=0x20, mem_read high from grant+1 until the RESP cycle, mem_write never high.
- Single write: m1_req, we=1, addr=0x5, wdata=0xA → mem_w_addr=0x5, mem_w_line=0xA, mem_write held until wrdy returns, then m1_ack; m1_err stays 0.
- Contention: both reqs held for 6 transactions → grant order m0, m1, m0, m1, m0, m1; no overlap of strobes; each ack is exactly one cycle.
- Exception: ram raises exc during WAIT_DONE of an m1 read at 0x7FF → m1_err pulse, no ack, strobe low next cycle, next grant proceeds normally.
- Timeout: TIMEOUT=8, ram keeps rrdy=1 forever → m0_err at cycle 9 after grant. Arbiter sits in DRAIN while wrdy=0 and grants nothing. Once both readys are 1, the next req is accepted.
- Reset mid-op: rst_n low during WAIT_DONE → all outputs 0 asynchronously, no ack or err; after release with both reqs high, m0 is granted first.

Source files
------------

// File: rtl/cpu32_mem_pkg.sv
// Shared types and constants for the CPU32 memory arbiter slice.
package cpu32_mem_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    localparam logic M_IFETCH = 1'b0;
    localparam logic M_DATA   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP,
        DRAIN
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the master that was not granted last wins.
module rr_arb2
    import cpu32_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic       o_valid,
    output logic       o_gnt
);

    logic r_rr_last;

    always_comb begin
        o_valid = |i_req;
        if (&i_req) begin
            o_gnt = ~r_rr_last;
        end else begin
            o_gnt = i_req[M_DATA];
        end
    end

    // Reset to M_DATA so that the instruction-fetch port wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last <= M_DATA;
        end else if (i_update) begin
            r_rr_last <= o_gnt;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one ram port between instruction fetch (m0) and load/store (m1), one
// transaction at a time, converting the ram ready handshake to req/ack/err.
//
// state     | meaning
// IDLE      | no transaction; arbitrate pending requests
// WAIT_BUSY | strobe held, waiting for the selected ready to drop
// WAIT_DONE | strobe held, waiting for the selected ready to return
// RESP      | one-cycle ack/err to the granted master
// DRAIN     | after timeout, wait until both readys are high again
module mem_arbiter
    import cpu32_mem_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [AW-1:0] mem_r_addr,
    output logic [AW-1:0] mem_w_addr,
    output logic [DW-1:0] mem_w_line,
    input  logic [DW-1:0] mem_r_line,
    output logic          mem_read,
    output logic          mem_write,
    input  logic          mem_rrdy,
    input  logic          mem_wrdy,
    input  logic          mem_exc
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    arb_state_t    r_state, w_state_nxt;
    logic          r_we, r_gnt;
    logic [CW-1:0] r_cnt;
    logic          r_m0_ack, r_m0_err, r_m1_ack, r_m1_err;
    logic          r_mem_read, r_mem_write;
    logic [AW-1:0] r_mem_r_addr, r_mem_w_addr;
    logic [DW-1:0] r_mem_w_line, r_m0_rdata, r_m1_rdata;

    logic          w_arb_valid, w_arb_gnt, w_grant, w_ack, w_err, w_rdy, w_tmo;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    rr_arb2 u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    ({m1_req, m0_req}),
        .i_update (w_grant),
        .o_valid  (w_arb_valid),
        .o_gnt    (w_arb_gnt)
    );

    assign w_sel_we    = (w_arb_gnt == M_DATA) ? m1_we    : m0_we;
    assign w_sel_addr  = (w_arb_gnt == M_DATA) ? m1_addr  : m0_addr;
    assign w_sel_wdata = (w_arb_gnt == M_DATA) ? m1_wdata : m0_wdata;
    assign w_rdy       = r_we ? mem_wrdy : mem_rrdy;
    // >= so a ready drop on the last busy cycle still times out in WAIT_DONE.
    assign w_tmo       = (r_cnt >= TMO_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_ack       = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_grant     = 1'b1;
                    w_state_nxt = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (mem_exc) begin
                    w_err       = 1'b1;
                    w_state_nxt = RESP;
                end else if (!w_rdy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (w_tmo) begin
                    w_err       = 1'b1;
                    w_state_nxt = DRAIN;
                end
            end
            WAIT_DONE: begin
                if (mem_exc) begin
                    w_err       = 1'b1;
                    w_state_nxt = RESP;
                end else if (w_rdy) begin
                    w_ack       = 1'b1;
                    w_state_nxt = RESP;
                end else if (w_tmo) begin
                    w_err       = 1'b1;
                    w_state_nxt = DRAIN;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            DRAIN: begin
                if (mem_rrdy && mem_wrdy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_m0_ack <= 1'b0;
            r_m0_err <= 1'b0;
            r_m1_ack <= 1'b0;
            r_m1_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_m0_ack <= w_ack && (r_gnt == M_IFETCH);
            r_m0_err <= w_err && (r_gnt == M_IFETCH);
            r_m1_ack <= w_ack && (r_gnt == M_DATA);
            r_m1_err <= w_err && (r_gnt == M_DATA);
            if (w_grant) begin
                r_cnt <= '0;
            end else if (r_state == WAIT_BUSY || r_state == WAIT_DONE) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Granted request is latched here; later changes on the master port are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_gnt        <= M_IFETCH;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_r_addr <= '0;
            r_mem_w_addr <= '0;
            r_mem_w_line <= '0;
        end else if (w_grant) begin
            r_we        <= w_sel_we;
            r_gnt       <= w_arb_gnt;
            r_mem_read  <= !w_sel_we;
            r_mem_write <= w_sel_we;
            if (w_sel_we) begin
                r_mem_w_addr <= w_sel_addr;
                r_mem_w_line <= w_sel_wdata;
            end else begin
                r_mem_r_addr <= w_sel_addr;
            end
        end else if (w_ack || w_err) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else if (w_ack && !r_we) begin
            if (r_gnt == M_DATA) begin
                r_m1_rdata <= mem_r_line;
            end else begin
                r_m0_rdata <= mem_r_line;
            end
        end
    end

    assign m0_ack     = r_m0_ack;
    assign m0_err     = r_m0_err;
    assign m1_ack     = r_m1_ack;
    assign m1_err     = r_m1_err;
    assign m0_rdata   = r_m0_rdata;
    assign m1_rdata   = r_m1_rdata;
    assign mem_read   = r_mem_read;
    assign mem_write  = r_mem_write;
    assign mem_r_addr = r_mem_r_addr;
    assign mem_w_addr = r_mem_w_addr;
    assign mem_w_line = r_mem_w_line;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: scripted ram behaviour per transaction and
// a transaction-level model predicting grant order, response cycle and data.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    localparam int SC_NORM = 0;
    localparam int SC_EXB  = 1;
    localparam int SC_EXD  = 2;
    localparam int SC_TMO  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr, mem_r_addr, mem_w_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_w_line, mem_r_line;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic          mem_read, mem_write, mem_rrdy, mem_wrdy, mem_exc;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .mem_r_addr(mem_r_addr), .mem_w_addr(mem_w_addr), .mem_w_line(mem_w_line),
        .mem_r_line(mem_r_line), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rrdy(mem_rrdy), .mem_wrdy(mem_wrdy), .mem_exc(mem_exc)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    bit          pend [2];
    bit          p_we [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wdata [2];
    logic [31:0] exp_rdata [2];
    logic [31:0] last_r_addr, last_w_addr, last_w_line;
    int          last_gnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic new_req(input int i);
        pend[i]    = 1'b1;
        p_we[i]    = 1'($urandom_range(0, 1));
        p_addr[i]  = $urandom;
        p_wdata[i] = $urandom;
    endtask

    task automatic drive_masters();
        m0_req = pend[0]; m0_we = p_we[0]; m0_addr = p_addr[0]; m0_wdata = p_wdata[0];
        m1_req = pend[1]; m1_we = p_we[1]; m1_addr = p_addr[1]; m1_wdata = p_wdata[1];
    endtask

    task automatic model_reset();
        last_gnt = 1;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        last_r_addr = '0; last_w_addr = '0; last_w_line = '0;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_flags"}, 64'({m0_ack, m0_err, m1_ack, m1_err, mem_read, mem_write}), 64'(0));
        chk({pfx, "_m0_rdata"}, 64'(m0_rdata), 64'(0));
        chk({pfx, "_m1_rdata"}, 64'(m1_rdata), 64'(0));
        chk({pfx, "_r_addr"}, 64'(mem_r_addr), 64'(0));
        chk({pfx, "_w_addr"}, 64'(mem_w_addr), 64'(0));
        chk({pfx, "_w_line"}, 64'(mem_w_line), 64'(0));
    endtask

    // One transaction; entered just before the negedge of an IDLE cycle (cycle 0 = grant).
    task automatic run_txn(input int sc, input int P, input int L, input int D, input bit both);
        int          g, R, fin;
        bit          we, is_ack, exc_rdy, sel_rdy, unsel_rdy, exc;
        logic [31:0] cap;
        @(negedge clk);
        chk("idle_strobe", 64'({mem_read, mem_write}), 64'(0));
        chk("idle_resp", 64'({m0_ack, m0_err, m1_ack, m1_err}), 64'(0));
        for (int i = 0; i < 2; i++) begin
            if (!pend[i] && (both || $urandom_range(0, 1) == 1)) new_req(i);
        end
        if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
        if (pend[0] && pend[1]) g = 1 - last_gnt;
        else                    g = pend[1] ? 1 : 0;
        last_gnt = g;
        we = p_we[g];
        if (we) begin
            last_w_addr = p_addr[g];
            last_w_line = p_wdata[g];
        end else begin
            last_r_addr = p_addr[g];
        end
        case (sc)
            SC_NORM: begin R = P + L + 2; fin = R + 1; end
            SC_EXB:  begin R = P + 2;     fin = R + 1; end
            SC_EXD:  begin R = P + 3;     fin = R + 1; end
            default: begin R = TMO + 1;   fin = TMO + D + 2; end
        endcase
        is_ack  = (sc == SC_NORM);
        exc_rdy = 1'($urandom_range(0, 1));
        cap     = '0;
        drive_masters();
        mem_rrdy = 1'b1; mem_wrdy = 1'b1; mem_exc = 1'b0; mem_r_line = $urandom;
        for (int k = 1; k < fin; k++) begin
            @(negedge clk);
            chk("rd_strobe", 64'(mem_read), 64'((k < R) && !we));
            chk("wr_strobe", 64'(mem_write), 64'((k < R) && we));
            chk("r_addr", 64'(mem_r_addr), 64'(last_r_addr));
            chk("w_addr", 64'(mem_w_addr), 64'(last_w_addr));
            chk("w_line", 64'(mem_w_line), 64'(last_w_line));
            chk("m0_ack", 64'(m0_ack), 64'(k == R && g == 0 && is_ack));
            chk("m0_err", 64'(m0_err), 64'(k == R && g == 0 && !is_ack));
            chk("m1_ack", 64'(m1_ack), 64'(k == R && g == 1 && is_ack));
            chk("m1_err", 64'(m1_err), 64'(k == R && g == 1 && !is_ack));
            if (k == R) begin
                if (is_ack && !we) exp_rdata[g] = cap;
                chk("m0_rdata", 64'(m0_rdata), 64'(exp_rdata[0]));
                chk("m1_rdata", 64'(m1_rdata), 64'(exp_rdata[1]));
                pend[g] = 1'b0;
                if (sc == SC_TMO && !pend[1 - g]) new_req(1 - g);
            end
            drive_masters();
            if (k < R) begin
                if (g == 0) begin m0_we = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom; end
                else        begin m1_we = 1'($urandom); m1_addr = $urandom; m1_wdata = $urandom; end
            end
            sel_rdy = 1'b1; unsel_rdy = 1'b1; exc = 1'b0;
            case (sc)
                SC_NORM: sel_rdy = !(k >= P + 1 && k <= P + L);
                SC_EXB:  exc = (k == P + 1);
                SC_EXD: begin
                    if (k == P + 1) sel_rdy = 1'b0;
                    if (k == P + 2) begin sel_rdy = exc_rdy; exc = 1'b1; end
                end
                default: unsel_rdy = !(k >= 1 && k < TMO + 1 + D);
            endcase
            mem_rrdy   = we ? unsel_rdy : sel_rdy;
            mem_wrdy   = we ? sel_rdy : unsel_rdy;
            mem_exc    = exc;
            mem_r_line = $urandom;
            if (k == R - 1) cap = mem_r_line;
        end
    endtask

    task automatic random_txn();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 6)      run_txn(SC_EXB, int'($urandom_range(0, 2)), 0, 0, 1'b0);
        else if (r == 7) run_txn(SC_EXD, int'($urandom_range(0, 2)), 0, 0, 1'b0);
        else if (r == 8) run_txn(SC_TMO, 0, 0, int'($urandom_range(0, 3)), 1'b0);
        else             run_txn(SC_NORM, int'($urandom_range(0, 2)), int'($urandom_range(1, 4)), 0, 1'b0);
    endtask

    task automatic reset_midop();
        @(negedge clk);
        pend[1] = 1'b0;
        new_req(0);
        p_we[0] = 1'b0;
        drive_masters();
        mem_rrdy = 1'b1; mem_wrdy = 1'b1; mem_exc = 1'b0;
        @(negedge clk);
        chk("pre_rst_read", 64'(mem_read), 64'(1));
        mem_rrdy = 1'b0;
        @(negedge clk);
        chk("pre_rst_read2", 64'(mem_read), 64'(1));
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all_zero("async_rst");
        repeat (2) begin
            @(negedge clk);
            chk_all_zero("in_rst");
        end
        mem_rrdy = 1'b1;
        new_req(0);
        new_req(1);
        drive_masters();
        m0_req = 1'b0;
        m1_req = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pend[0] = 1'b0; pend[1] = 1'b0;
        p_we[0] = 1'b0; p_we[1] = 1'b0;
        p_addr[0] = '0; p_addr[1] = '0; p_wdata[0] = '0; p_wdata[1] = '0;
        model_reset();
        drive_masters();
        mem_rrdy = 1'b1; mem_wrdy = 1'b1; mem_exc = 1'b0; mem_r_line = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        run_txn(SC_NORM, 0, 1, 0, 1'b1);
        repeat (50) random_txn();
        repeat (6) run_txn(SC_NORM, int'($urandom_range(0, 2)), int'($urandom_range(1, 4)), 0, 1'b1);
        run_txn(SC_TMO, 0, 0, 3, 1'b0);
        run_txn(SC_EXD, 1, 0, 0, 1'b0);
        run_txn(SC_NORM, 0, 2, 0, 1'b0);
        reset_midop();
        run_txn(SC_NORM, 0, 2, 0, 1'b1);
        repeat (15) random_txn();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
